res_scoreboard: RTL
===================

// Module: res_scoreboard
// PURPOSE
//  Parametrised result-source scoreboard for the pipelined MIPS core. It keeps a shift register with one
//  entry per post-decode stage (E, M, W, ...) for each in-flight producer. Each entry holds the dest reg,
//  result source (ALU/DM/PC/NW) and a Tnew countdown. It also models the multi-cycle MDU as a busy counter.
//  From these it produces the decode-stage stall and the forward-source selects. Sits beside the D stage.
// PARAMETERS
//  NUM_STAGES  3   tracked post-decode stages (1=E ... NUM_STAGES=W); legal 2..6
//  MULT_LAT    5   MDU busy cycles for mult/multu
//  DIV_LAT     10  MDU busy cycles for div/divu
//  SELW        $clog2(NUM_STAGES+1)  width of forward selects (derived, localparam)
// PORTS
//  clk          in   1     clock, rising edge
//  reset_n      in   1     asynchronous reset, active-low
//  d_valid      in   1     D-stage instruction valid (0 = bubble)
//  d_dst        in   5     D-stage destination reg (0 = none)
//  d_res        in   2     D-stage result source: 00 NW, 01 ALU, 10 DM (loads, mfc0), 11 PC (jal/jalr)
//  d_rs,d_rt    in   5     D-stage source regs
//  d_rs_tuse    in   2     cycles until rs is consumed (0 = D, 1 = E, 2 = M)
//  d_rt_tuse    in   2     same for rt
//  d_md_start   in   1     D instr is mult/multu/div/divu
//  d_md_is_div  in   1     selects DIV_LAT instead of MULT_LAT
//  d_md_use     in   1     D instr is mfhi/mflo/mthi/mtlo
//  flush        in   1     exception/eret: kill younger in-flight instrs
//  stall        out  1     hold PC and D; inject bubble into E
//  fwd_rs_sel   out  SELW  youngest matching producer stage for rs (0 = register file)
//  fwd_rt_sel   out  SELW  same for rt
//  md_busy      out  1     MDU counter non-zero
// BEHAVIOUR
//  Reset (async, reset_n=0): all entries invalid, Tnew=0, MDU counter=0 -> stall=0, selects=0, md_busy=0.
//  Entry fill (posedge): entry[k+1] <= entry[k] for k=1..NUM_STAGES-1, and entry[NUM_STAGES] leaves.
//   entry[1] <= D instr if d_valid & !stall & !flush; otherwise it becomes a bubble.
//  Tnew on entry into E: ALU=1, DM=2, PC=0, NW=0. Tnew decrements by 1 per shift and saturates at 0.
//  Match rule: entry valid, res!=NW, dst!=0, and dst==src. Register 0 never matches and never stalls.
//  Youngest wins: the lowest stage index among matches drives the sel, and older matches are ignored.
//  Data stall: for src in {rs, rt}, stall when the youngest match has Tnew > tuse for that src.
//   Applies only when d_valid=1.
//  fwd_*_sel: stage index of the youngest match, or 0 if none. Valid whenever stall=0.
//   Downstream muxes index by this value; the stage carries it with the instr.
//  MDU counter: on d_md_start & !stall & !flush, load MULT_LAT or DIV_LAT. It then decrements to 0.
//   md_busy = (counter != 0).
//  MDU stall: when d_valid & (d_md_use | d_md_start) & (md_busy | md start currently in E).
//   stall = data stall OR MDU stall, purely combinational from current state and D inputs.
//  Flush: entries 1..NUM_STAGES-1 cleared and D not inserted. Entry[NUM_STAGES] (W) still commits.
//   The MDU counter is NOT cleared; the operation already issued completes.
//  Simultaneous flush & stall: flush wins, and stall has no effect on the next state.
//  Reset mid-operation clears everything immediately; there is no pending state.
// STRUCTURE
//  Shared package core_pkg: RES_NW/ALU/DM/PC codes (2 bit), TNEW_ALU/DM/PC constants, and
//   typedef sb_entry_t {valid, dst[4:0], res[1:0], tnew[1:0]}. The core's opcode decoder also uses these.
//  One sub-module, sb_match_pri: a priority match of one src over NUM_STAGES entries that returns
//   the sel and the youngest Tnew. It is instantiated twice, for rs and rt.
//  MDU counter is inline, width $clog2(DIV_LAT+1).
// TESTING
//  1. addu $3 in E, then D: beq $3 (tuse 0) -> stall=1 for 1 cycle; next cycle fwd_rs_sel=2, stall=0.
//  2. lw $5 in E, D: addu $6,$5 (tuse 1) -> stall=1 for 1 cycle; after that fwd_rs_sel=2,
//     then rs reaches W with sel 3.
//  3. addu $4 in E and lw $4 in M, D reads $4 with tuse 1 -> fwd_rs_sel=1, and the older lw is ignored.
//  4. $0 dst load in E, D reads $0 with tuse 0 -> stall=0, sel=0.
//  5. div issued, then mflo in D the next cycle -> stall=1 for DIV_LAT+1 cycles, md_busy drops,
//     then stall=0.
//  6. flush with entries in E, M and W -> next cycle E and M invalid, W entry shifted out. reset_n low
//     mid-div -> md_busy=0 with no clock edge.

Source files
------------

// File: rtl/core_pkg.sv
// Shared core definitions: result-source codes, Tnew constants and the
// scoreboard entry layout used by the hazard logic and the opcode decoder.
package core_pkg;

  localparam logic [1:0] RES_NW  = 2'b00;
  localparam logic [1:0] RES_ALU = 2'b01;
  localparam logic [1:0] RES_DM  = 2'b10;
  localparam logic [1:0] RES_PC  = 2'b11;

  localparam logic [1:0] TNEW_ALU = 2'd1;
  localparam logic [1:0] TNEW_DM  = 2'd2;
  localparam logic [1:0] TNEW_PC  = 2'd0;

  typedef struct packed {
    logic       valid;
    logic [4:0] dst;
    logic [1:0] res;
    logic [1:0] tnew;
  } sb_entry_t;

  // Cycles until the result exists, counted from the producer's entry into E.
  function automatic logic [1:0] tnew_of(input logic [1:0] res);
    case (res)
      RES_ALU: tnew_of = TNEW_ALU;
      RES_DM:  tnew_of = TNEW_DM;
      RES_PC:  tnew_of = TNEW_PC;
      default: tnew_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/sb_match_pri.sv
// Priority match of one source register against all in-flight entries;
// reports the youngest producing stage and its remaining Tnew.
module sb_match_pri
  import core_pkg::*;
#(
  parameter int NUM_STAGES = 3,
  parameter int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  sb_entry_t [NUM_STAGES:1] entries,
  input  logic [4:0]               src,
  output logic [SELW-1:0]          sel,
  output logic [1:0]               tnew
);

  logic [NUM_STAGES:1] hit;

  genvar gi;
  generate
    for (gi = 1; gi <= NUM_STAGES; gi++) begin : g_hit
      // $0 and non-writing producers never match.
      assign hit[gi] = entries[gi].valid && (entries[gi].res != RES_NW) &&
                       (entries[gi].dst != 5'd0) && (entries[gi].dst == src);
    end
  endgenerate

  // Scan oldest to youngest so the lowest stage index wins.
  always_comb begin
    sel  = '0;
    tnew = 2'd0;
    for (int k = NUM_STAGES; k >= 1; k--) begin
      if (hit[k]) begin
        sel  = SELW'(k);
        tnew = entries[k].tnew;
      end
    end
  end

endmodule

// File: rtl/res_scoreboard.sv
// Result-source scoreboard beside the D stage: tracks in-flight producers and
// the MDU busy time, and derives the decode stall and forward selects.
module res_scoreboard
  import core_pkg::*;
#(
  parameter int  NUM_STAGES = 3,
  parameter int  MULT_LAT   = 5,
  parameter int  DIV_LAT    = 10,
  localparam int SELW       = $clog2(NUM_STAGES + 1)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            d_valid,
  input  logic [4:0]      d_dst,
  input  logic [1:0]      d_res,
  input  logic [4:0]      d_rs,
  input  logic [4:0]      d_rt,
  input  logic [1:0]      d_rs_tuse,
  input  logic [1:0]      d_rt_tuse,
  input  logic            d_md_start,
  input  logic            d_md_is_div,
  input  logic            d_md_use,
  input  logic            flush,
  output logic            stall,
  output logic [SELW-1:0] fwd_rs_sel,
  output logic [SELW-1:0] fwd_rt_sel,
  output logic            md_busy
);

  localparam int CNTW = $clog2(DIV_LAT + 1);

  sb_entry_t [NUM_STAGES:1]   ent_reg;
  sb_entry_t [NUM_STAGES:1]   ent_next;
  sb_entry_t [NUM_STAGES-1:1] ent_aged;

  logic [CNTW-1:0] md_cnt_reg, md_cnt_next;
  logic            md_in_e_reg, md_in_e_next;
  logic [1:0]      rs_tnew, rt_tnew;
  logic            data_stall, md_stall, issue, md_issue;

  sb_match_pri #(.NUM_STAGES(NUM_STAGES), .SELW(SELW)) u_match_rs (
    .entries (ent_reg),
    .src     (d_rs),
    .sel     (fwd_rs_sel),
    .tnew    (rs_tnew)
  );

  sb_match_pri #(.NUM_STAGES(NUM_STAGES), .SELW(SELW)) u_match_rt (
    .entries (ent_reg),
    .src     (d_rt),
    .sel     (fwd_rt_sel),
    .tnew    (rt_tnew)
  );

  // Tnew is zero when nothing matches, so a miss can never stall.
  assign data_stall = d_valid && ((rs_tnew > d_rs_tuse) || (rt_tnew > d_rt_tuse));
  assign md_busy    = (md_cnt_reg != '0);
  assign md_stall   = d_valid && (d_md_use || d_md_start) && (md_busy || md_in_e_reg);
  assign stall      = data_stall || md_stall;

  assign issue    = d_valid && !stall && !flush;
  assign md_issue = issue && d_md_start;

  genvar gi;
  generate
    for (gi = 1; gi < NUM_STAGES; gi++) begin : g_age
      always_comb begin
        ent_aged[gi]      = ent_reg[gi];
        ent_aged[gi].tnew = (ent_reg[gi].tnew == 2'd0) ? 2'd0 : ent_reg[gi].tnew - 2'd1;
      end
    end
  endgenerate

  // The W entry always retires; a flush empties everything younger than it.
  always_comb begin
    ent_next = '0;
    if (!flush) begin
      for (int k = 2; k <= NUM_STAGES; k++) begin
        ent_next[k] = ent_aged[k-1];
      end
      if (issue) begin
        ent_next[1].valid = 1'b1;
        ent_next[1].dst   = d_dst;
        ent_next[1].res   = d_res;
        ent_next[1].tnew  = tnew_of(d_res);
      end
    end
  end

  // The count holds while the operation sits in E, so a dependent op waits LAT+1 cycles.
  always_comb begin
    md_cnt_next  = md_cnt_reg;
    md_in_e_next = md_issue;
    if (md_issue) begin
      md_cnt_next = d_md_is_div ? CNTW'(DIV_LAT) : CNTW'(MULT_LAT);
    end else if (md_busy && !md_in_e_reg) begin
      md_cnt_next = md_cnt_reg - CNTW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ent_reg     <= '0;
      md_cnt_reg  <= '0;
      md_in_e_reg <= 1'b0;
    end else begin
      ent_reg     <= ent_next;
      md_cnt_reg  <= md_cnt_next;
      md_in_e_reg <= md_in_e_next;
    end
  end

endmodule
